// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the slave memory.
//   - Response codes (OKAY, SLVERR) and burst type codes (FIXED, INCR, WRAP)
//   - Write and read FSM state encodings
//   - beat_ok(): decides whether a beat may touch memory
package axi4_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Only INCR bursts whose word index lands inside the array are serviced.
    function automatic logic beat_ok(input logic [31:0] addr, input logic [1:0] burst,
                                     input int unsigned lsb, input int unsigned depth);
        logic [31:0] idx;
        idx = addr >> lsb;
        return (burst == BURST_INCR) && (idx < depth);
    endfunction

endpackage

// File: rtl/axi4_slave_mem_ram.sv
// Word-organised RAM behind the AXI4 slave.
// Ports:
//   clk, rst_n        clock, async active-low reset (output register only)
//   we, wstrb, waddr, wdata   byte-enabled write port
//   re, rclr, raddr   synchronous read; rclr loads zero instead of the array word
//   rdata             registered read data (old value on same-cycle write)
module axi4_slave_mem_ram #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 256,
    localparam int unsigned AW        = $clog2(DEPTH),
    localparam int unsigned NB        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [NB-1:0]         wstrb,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= rclr ? '0 : mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave backed by an on-chip RAM. Full-width transfers only.
// Ports:
//   s00_axi_aclk / s00_axi_aresetn   clock, async active-low reset
//   AW channel: awid, awaddr, awlen, awburst, awvalid -> awready
//   W  channel: wdata, wstrb, wlast, wvalid -> wready
//   B  channel: bid, bresp, bvalid <- bready
//   AR channel: arid, araddr, arlen, arburst, arvalid -> arready
//   R  channel: rid, rdata, rresp, rlast, rvalid <- rready
// Non-INCR bursts, out-of-range beats and wlast mismatches answer SLVERR.
module axi4_slave_mem
    import axi4_pkg::*;
#(
    parameter int unsigned C_S00_AXI_ID_WIDTH   = 1,
    parameter int unsigned C_S00_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S00_AXI_MEM_DEPTH  = 256
) (
    input  logic                                s00_axi_aclk,
    input  logic                                s00_axi_aresetn,
    input  logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_awid,
    input  logic [31:0]                         s00_axi_awaddr,
    input  logic [7:0]                          s00_axi_awlen,
    input  logic [1:0]                          s00_axi_awburst,
    input  logic                                s00_axi_awvalid,
    output logic                                s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                                s00_axi_wlast,
    input  logic                                s00_axi_wvalid,
    output logic                                s00_axi_wready,
    output logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_bid,
    output logic [1:0]                          s00_axi_bresp,
    output logic                                s00_axi_bvalid,
    input  logic                                s00_axi_bready,
    input  logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_arid,
    input  logic [31:0]                         s00_axi_araddr,
    input  logic [7:0]                          s00_axi_arlen,
    input  logic [1:0]                          s00_axi_arburst,
    input  logic                                s00_axi_arvalid,
    output logic                                s00_axi_arready,
    output logic [C_S00_AXI_ID_WIDTH-1:0]       s00_axi_rid,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                          s00_axi_rresp,
    output logic                                s00_axi_rlast,
    output logic                                s00_axi_rvalid,
    input  logic                                s00_axi_rready
);

    localparam int unsigned IDW   = C_S00_AXI_ID_WIDTH;
    localparam int unsigned BYTES = C_S00_AXI_DATA_WIDTH / 8;
    localparam int unsigned LSB   = $clog2(BYTES);
    localparam int unsigned AW    = $clog2(C_S00_AXI_MEM_DEPTH);

    // Holds both ready outputs low while in reset and releases them one cycle later.
    logic init_q;

    wr_state_e      wstate_q, wstate_d;
    logic [IDW-1:0] wid_q, wid_d;
    logic [31:0]    waddr_q, waddr_d;
    logic [7:0]     wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [1:0]     wburst_q, wburst_d;
    logic           werr_q, werr_d;

    rd_state_e      rstate_q, rstate_d;
    logic [IDW-1:0] rid_q, rid_d;
    logic [31:0]    raddr_q, raddr_d;
    logic [7:0]     rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [1:0]     rburst_q, rburst_d, rresp_q, rresp_d;
    logic           rlast_q, rlast_d;

    logic           ram_we, ram_re, ram_rclr;
    logic [AW-1:0]  ram_waddr, ram_raddr;
    logic [31:0]    rd_addr;
    logic [1:0]     rd_burst;
    logic           rd_load, rd_ok;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            init_q   <= 1'b0;
            wstate_q <= W_IDLE;
            wid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wcnt_q   <= '0;
            wburst_q <= '0;
            werr_q   <= 1'b0;
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rcnt_q   <= '0;
            rburst_q <= '0;
            rresp_q  <= RESP_OKAY;
            rlast_q  <= 1'b0;
        end else begin
            init_q   <= 1'b1;
            wstate_q <= wstate_d;
            wid_q    <= wid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wcnt_q   <= wcnt_d;
            wburst_q <= wburst_d;
            werr_q   <= werr_d;
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rcnt_q   <= rcnt_d;
            rburst_q <= rburst_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    // Write path
    always_comb begin
        wstate_d = wstate_q;
        wid_d    = wid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wcnt_d   = wcnt_q;
        wburst_d = wburst_q;
        werr_d   = werr_q;
        ram_we   = 1'b0;
        unique case (wstate_q)
            W_IDLE: begin
                if (init_q && s00_axi_awvalid) begin
                    wid_d    = s00_axi_awid;
                    waddr_d  = s00_axi_awaddr;
                    wlen_d   = s00_axi_awlen;
                    wburst_d = s00_axi_awburst;
                    wcnt_d   = '0;
                    werr_d   = 1'b0;
                    wstate_d = W_DATA;
                end
            end
            W_DATA: begin
                if (s00_axi_wvalid) begin
                    if (beat_ok(waddr_q, wburst_q, LSB, C_S00_AXI_MEM_DEPTH)) begin
                        ram_we = 1'b1;
                    end else begin
                        werr_d = 1'b1;
                    end
                    if (s00_axi_wlast != (wcnt_q == wlen_q)) begin
                        werr_d = 1'b1;
                    end
                    if (wcnt_q == wlen_q) begin
                        wstate_d = W_RESP;
                    end else begin
                        wcnt_d  = wcnt_q + 8'd1;
                        waddr_d = waddr_q + 32'(BYTES);
                    end
                end
            end
            W_RESP: begin
                if (s00_axi_bready) begin
                    wstate_d = W_IDLE;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    assign ram_waddr       = AW'(waddr_q >> LSB);
    assign s00_axi_awready = init_q && (wstate_q == W_IDLE);
    assign s00_axi_wready  = (wstate_q == W_DATA);
    assign s00_axi_bvalid  = (wstate_q == W_RESP);
    assign s00_axi_bresp   = (s00_axi_bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;
    assign s00_axi_bid     = wid_q;

    // Read path: each beat is fetched the cycle before it is presented, so the
    // first beat is loaded on the AR handshake and later beats on each R handshake.
    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rcnt_d   = rcnt_q;
        rburst_d = rburst_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        rd_load  = 1'b0;
        rd_addr  = s00_axi_araddr;
        rd_burst = s00_axi_arburst;
        unique case (rstate_q)
            R_IDLE: begin
                if (init_q && s00_axi_arvalid) begin
                    rid_d    = s00_axi_arid;
                    rlen_d   = s00_axi_arlen;
                    rburst_d = s00_axi_arburst;
                    rcnt_d   = '0;
                    rlast_d  = (s00_axi_arlen == 8'd0);
                    rd_load  = 1'b1;
                    rstate_d = R_DATA;
                end
            end
            R_DATA: begin
                if (s00_axi_rready) begin
                    if (rlast_q) begin
                        rlast_d  = 1'b0;
                        rstate_d = R_IDLE;
                    end else begin
                        rcnt_d   = rcnt_q + 8'd1;
                        rlast_d  = ((rcnt_q + 8'd1) == rlen_q);
                        rd_addr  = raddr_q + 32'(BYTES);
                        rd_burst = rburst_q;
                        rd_load  = 1'b1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase
        rd_ok = beat_ok(rd_addr, rd_burst, LSB, C_S00_AXI_MEM_DEPTH);
        if (rd_load) begin
            raddr_d = rd_addr;
            rresp_d = rd_ok ? RESP_OKAY : RESP_SLVERR;
        end
    end

    assign ram_re          = rd_load;
    assign ram_rclr        = !rd_ok;
    assign ram_raddr       = AW'(rd_addr >> LSB);
    assign s00_axi_arready = init_q && (rstate_q == R_IDLE);
    assign s00_axi_rvalid  = (rstate_q == R_DATA);
    assign s00_axi_rid     = rid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rlast   = rlast_q;

    axi4_slave_mem_ram #(
        .DATA_WIDTH (C_S00_AXI_DATA_WIDTH),
        .DEPTH      (C_S00_AXI_MEM_DEPTH)
    ) u_ram (
        .clk   (s00_axi_aclk),
        .rst_n (s00_axi_aresetn),
        .we    (ram_we),
        .wstrb (s00_axi_wstrb),
        .waddr (ram_waddr),
        .wdata (s00_axi_wdata),
        .re    (ram_re),
        .rclr  (ram_rclr),
        .raddr (ram_raddr),
        .rdata (s00_axi_rdata)
    );

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Bench for axi4_slave_mem: directed and random bursts, byte-level memory model,
// expected B/R responses queued at issue and popped by independent monitors.
module tb_axi4_slave_mem;

    localparam int IDW   = 1;
    localparam int DW    = 32;
    localparam int DEPTH = 256;

    logic            clk, rst_n;
    logic [IDW-1:0]  awid, bid, arid, rid;
    logic [31:0]     awaddr, araddr;
    logic [7:0]      awlen, arlen;
    logic [1:0]      awburst, arburst, bresp, rresp;
    logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic            arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;

    axi4_slave_mem #(
        .C_S00_AXI_ID_WIDTH   (IDW),
        .C_S00_AXI_DATA_WIDTH (DW),
        .C_S00_AXI_MEM_DEPTH  (DEPTH)
    ) dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (rst_n),
        .s00_axi_awid    (awid),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awlen   (awlen),
        .s00_axi_awburst (awburst),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wlast   (wlast),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bid     (bid),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_arid    (arid),
        .s00_axi_araddr  (araddr),
        .s00_axi_arlen   (arlen),
        .s00_axi_arburst (arburst),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rid     (rid),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rlast   (rlast),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0]    data;
        logic [1:0]     resp;
        logic           last;
        logic [IDW-1:0] id;
    } rbeat_t;

    typedef struct {
        logic [1:0]     resp;
        logic [IDW-1:0] id;
    } bexp_t;

    rbeat_t exp_r[$];
    bexp_t  exp_b[$];

    logic [7:0]  mem_m [DEPTH*4];   // byte-addressed reference memory
    logic [31:0] wd [256];
    logic [3:0]  ws [256];
    int rmode = 0;                  // 0: rready high, 1: random, 2: toggling
    int bmode = 0;                  // 0: bready high, 1: random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_range(input logic [31:0] a, input logic [1:0] burst);
        return (burst == 2'b01) && ((a / 4) < DEPTH);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base;
        base = int'(a / 4) * 4;
        return {mem_m[base+3], mem_m[base+2], mem_m[base+1], mem_m[base]};
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int base;
        base = int'(a / 4) * 4;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) mem_m[base+b] = d[b*8 +: 8];
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0:       return awready;
            1:       return wready;
            default: return arready;
        endcase
    endfunction

    task automatic wait_ready(input int w, input string name);
        int n;
        n = 0;
        while (!sig(w) && n < 1000) begin
            tick();
            n++;
        end
        check(name, 64'(sig(w)), 64'd1);
    endtask

    task automatic wait_b_done();
        int n;
        n = 0;
        while (exp_b.size() > 0 && n < 2000) begin
            tick();
            n++;
        end
        check("b_drained", 64'(exp_b.size()), 64'd0);
        check("awready_after_b", 64'(awready), 64'd1);
    endtask

    task automatic wait_r_done();
        int n;
        n = 0;
        while (exp_r.size() > 0 && n < 4000) begin
            tick();
            n++;
        end
        check("r_drained", 64'(exp_r.size()), 64'd0);
        check("arready_after_rlast", 64'(arready), 64'd1);
    endtask

    // wlast_at < 0 means wlast on the final beat; otherwise wlast only on beat wlast_at.
    task automatic do_write(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                            input logic [1:0] burst, input int wlast_at);
        logic        err;
        logic [31:0] a;
        logic        lst;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a   = addr + 32'(4 * i);
            lst = (wlast_at < 0) ? (i == len) : (i == wlast_at);
            if (in_range(a, burst)) model_write(a, wd[i], ws[i]);
            else err = 1'b1;
            if (lst != (i == len)) err = 1'b1;
        end
        exp_b.push_back('{resp: err ? 2'b10 : 2'b00, id: id});
        awid = id; awaddr = addr; awlen = 8'(len); awburst = burst; awvalid = 1'b1;
        wait_ready(0, "awready_wait");
        tick();
        awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            wdata  = wd[i];
            wstrb  = ws[i];
            wlast  = (wlast_at < 0) ? (i == len) : (i == wlast_at);
            wvalid = 1'b1;
            wait_ready(1, "wready_wait");
            tick();
            wvalid = 1'b0;
        end
        wait_b_done();
    endtask

    task automatic do_read(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
        logic [31:0] a;
        for (int i = 0; i <= len; i++) begin
            a = addr + 32'(4 * i);
            if (in_range(a, burst)) begin
                exp_r.push_back('{data: model_word(a), resp: 2'b00, last: (i == len), id: id});
            end else begin
                exp_r.push_back('{data: 32'h0, resp: 2'b10, last: (i == len), id: id});
            end
        end
        arid = id; araddr = addr; arlen = 8'(len); arburst = burst; arvalid = 1'b1;
        wait_ready(2, "arready_wait");
        tick();
        arvalid = 1'b0;
        check("rvalid_next_cycle", 64'(rvalid), 64'd1);
        wait_r_done();
    endtask

    task automatic check_reset_outputs();
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_wready", 64'(wready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_bresp", 64'(bresp), 64'd0);
        check("rst_rresp", 64'(rresp), 64'd0);
        check("rst_bid", 64'(bid), 64'd0);
        check("rst_rid", 64'(rid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
    endtask

    // Ready drivers
    initial begin
        rready = 1'b1;
        bready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       rready = 1'b1;
                1:       rready = 1'($urandom_range(0, 1));
                default: rready = ~rready;
            endcase
            bready = (bmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // R monitor: checks beats against the queue and holds stalled beats steady.
    initial begin
        logic        stalled;
        logic [31:0] hd;
        logic [1:0]  hr;
        logic        hl;
        rbeat_t      e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stalled = 1'b0;
            end else begin
                if (stalled && rvalid) begin
                    check("r_hold_data", 64'(rdata), 64'(hd));
                    check("r_hold_resp", 64'(rresp), 64'(hr));
                    check("r_hold_last", 64'(rlast), 64'(hl));
                end
                if (rvalid && rready) begin
                    if (exp_r.size() == 0) begin
                        check("r_unexpected_beat", 64'(rvalid), 64'd0);
                    end else begin
                        e = exp_r.pop_front();
                        check("r_data", 64'(rdata), 64'(e.data));
                        check("r_resp", 64'(rresp), 64'(e.resp));
                        check("r_last", 64'(rlast), 64'(e.last));
                        check("r_id", 64'(rid), 64'(e.id));
                    end
                    stalled = 1'b0;
                end else if (rvalid) begin
                    stalled = 1'b1;
                    hd = rdata;
                    hr = rresp;
                    hl = rlast;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    // B monitor
    initial begin
        bexp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bvalid && bready) begin
                if (exp_b.size() == 0) begin
                    check("b_unexpected_resp", 64'(bvalid), 64'd0);
                end else begin
                    e = exp_b.pop_front();
                    check("b_resp", 64'(bresp), 64'(e.resp));
                    check("b_id", 64'(bid), 64'(e.id));
                end
            end
        end
    end

    initial begin
        logic [1:0] br;
        int         len, wl;
        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0;
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();
        check("awready_after_release", 64'(awready), 64'd1);
        check("arready_after_release", 64'(arready), 64'd1);

        // Fill the whole array so every later read has a known value.
        for (int i = 0; i < 256; i++) begin
            wd[i] = $urandom();
            ws[i] = 4'hF;
        end
        do_write(1'b0, 32'h0, 255, 2'b01, -1);

        // Basic 4-beat INCR write and read back.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hA0 + 32'(i);
            ws[i] = 4'hF;
        end
        do_write(1'b1, 32'h10, 3, 2'b01, -1);
        do_read(1'b1, 32'h10, 3, 2'b01);

        // Byte strobes: expect 0x1122FF44.
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        do_write(1'b0, 32'h0, 0, 2'b01, -1);
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'h2;
        do_write(1'b0, 32'h0, 0, 2'b01, -1);
        do_read(1'b0, 32'h0, 0, 2'b01);

        // Second beat runs past the end of the array.
        do_read(1'b1, 32'h3FC, 1, 2'b01);

        // Stalled 8-beat read.
        rmode = 2;
        do_read(1'b0, 32'h40, 7, 2'b01);
        rmode = 0;

        // Early wlast, then a WRAP burst that must leave memory untouched.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'hC0DE0000 + 32'(i);
            ws[i] = 4'hF;
        end
        do_write(1'b1, 32'h20, 3, 2'b01, 2);
        do_write(1'b0, 32'h30, 3, 2'b10, -1);
        do_read(1'b0, 32'h20, 7, 2'b01);

        // Random traffic.
        rmode = 1;
        bmode = 1;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 7))
                0:       br = 2'b00;
                1:       br = 2'b10;
                2:       br = 2'b11;
                default: br = 2'b01;
            endcase
            len = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i <= len; i++) begin
                    wd[i] = $urandom();
                    ws[i] = 4'($urandom_range(0, 15));
                end
                wl = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 16)) : -1;
                do_write(1'($urandom_range(0, 1)), $urandom_range(0, 32'h43F), len, br, wl);
            end else begin
                do_read(1'($urandom_range(0, 1)), $urandom_range(0, 32'h43F), len, br);
            end
        end
        rmode = 0;
        bmode = 0;

        // Reset during the third beat of a 4-beat write.
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h5A5A0000 + 32'(i);
            ws[i] = 4'hF;
        end
        awid = 1'b1; awaddr = 32'h100; awlen = 8'd3; awburst = 2'b01; awvalid = 1'b1;
        wait_ready(0, "awready_wait");
        tick();
        awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wdata = wd[i]; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
            wait_ready(1, "wready_wait");
            model_write(32'h100 + 32'(4 * i), wd[i], 4'hF);
            tick();
        end
        wdata = wd[2];
        wait_ready(1, "wready_wait");
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        wvalid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("awready_after_midburst_reset", 64'(awready), 64'd1);
        repeat (3) tick();
        check("no_b_after_reset", 64'(bvalid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            wd[i] = 32'h77000000 + 32'(i);
            ws[i] = 4'hF;
        end
        do_write(1'b0, 32'h200, 3, 2'b01, -1);
        do_read(1'b1, 32'h100, 3, 2'b01);
        do_read(1'b0, 32'h200, 3, 2'b01);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
